// File: rtl/ps2_kbd_display_if.sv
// ============================================================================
// Module   : ps2_kbd_display_if
// Brief    : Board-level signal bundle for the PS/2 keyboard display block.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ps2_kbd_display_if;
    logic [4:0]  btn;
    logic [7:0]  sw;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] ledr;
    logic [7:0]  seg0;
    logic [7:0]  seg1;
    logic [7:0]  seg2;
    logic [7:0]  seg3;
    logic [7:0]  seg4;
    logic [7:0]  seg5;
    logic [7:0]  seg6;
    logic [7:0]  seg7;

    modport master (
        output btn, sw, ps2_clk, ps2_data,
        input  ledr, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
    );

    modport slave (
        input  btn, sw, ps2_clk, ps2_data,
        output ledr, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
    );
endinterface

`default_nettype wire

// File: rtl/ps2_kbd_display.sv
// ============================================================================
// Module   : ps2_kbd_display
// Brief    : PS/2 keyboard receiver showing scan code, ASCII and press count
//            on seven-segment digits, plus switch/button LEDs and running light.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_kbd_display #(
    parameter int LED_DIV     = 5000000,
    parameter int PS2_TIMEOUT = 50000
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    ps2_kbd_display_if.slave   io_kbd
);

    localparam int c_DIV_W = $clog2(LED_DIV + 1);
    localparam int c_TO_W  = $clog2(PS2_TIMEOUT + 1);

    logic [2:0]          r_clk_s;
    logic [1:0]          r_data_s;
    logic [3:0]          r_bit_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [10:0]         r_frame;
    logic                r_frame_done;
    logic                r_break;
    logic                r_held;
    logic [7:0]          r_cur;
    logic [7:0]          r_press;
    logic [c_DIV_W-1:0]  r_div;
    logic [2:0]          r_led;
    logic [7:0]          r_seg0, r_seg1, r_seg2, r_seg3, r_seg4, r_seg5;

    logic                w_fall;
    logic [7:0]          w_byte;
    logic                w_frame_ok;
    logic [7:0]          w_ascii;
    logic [7:0]          w_seg0, w_seg1, w_seg2, w_seg3, w_seg4, w_seg5;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        case (n)
            4'h0: f_hex = 8'hC0;  4'h1: f_hex = 8'hF9;
            4'h2: f_hex = 8'hA4;  4'h3: f_hex = 8'hB0;
            4'h4: f_hex = 8'h99;  4'h5: f_hex = 8'h92;
            4'h6: f_hex = 8'h82;  4'h7: f_hex = 8'hF8;
            4'h8: f_hex = 8'h80;  4'h9: f_hex = 8'h90;
            4'hA: f_hex = 8'h88;  4'hB: f_hex = 8'h83;
            4'hC: f_hex = 8'hC6;  4'hD: f_hex = 8'hA1;
            4'hE: f_hex = 8'h86;  default: f_hex = 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] f_ascii(input logic [7:0] code);
        case (code)
            8'h1C: f_ascii = 8'h41;  8'h32: f_ascii = 8'h42;  8'h21: f_ascii = 8'h43;
            8'h23: f_ascii = 8'h44;  8'h24: f_ascii = 8'h45;  8'h2B: f_ascii = 8'h46;
            8'h34: f_ascii = 8'h47;  8'h33: f_ascii = 8'h48;  8'h43: f_ascii = 8'h49;
            8'h3B: f_ascii = 8'h4A;  8'h42: f_ascii = 8'h4B;  8'h4B: f_ascii = 8'h4C;
            8'h3A: f_ascii = 8'h4D;  8'h31: f_ascii = 8'h4E;  8'h44: f_ascii = 8'h4F;
            8'h4D: f_ascii = 8'h50;  8'h15: f_ascii = 8'h51;  8'h2D: f_ascii = 8'h52;
            8'h1B: f_ascii = 8'h53;  8'h2C: f_ascii = 8'h54;  8'h3C: f_ascii = 8'h55;
            8'h2A: f_ascii = 8'h56;  8'h1D: f_ascii = 8'h57;  8'h22: f_ascii = 8'h58;
            8'h35: f_ascii = 8'h59;  8'h1A: f_ascii = 8'h5A;
            8'h45: f_ascii = 8'h30;  8'h16: f_ascii = 8'h31;  8'h1E: f_ascii = 8'h32;
            8'h26: f_ascii = 8'h33;  8'h25: f_ascii = 8'h34;  8'h2E: f_ascii = 8'h35;
            8'h36: f_ascii = 8'h36;  8'h3D: f_ascii = 8'h37;  8'h3E: f_ascii = 8'h38;
            8'h46: f_ascii = 8'h39;
            default: f_ascii = 8'h00;
        endcase
    endfunction

    // Data uses two stages so it lines up with stage2 of the clock chain.
    assign w_fall = ~r_clk_s[1] & r_clk_s[2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clk_s  <= '0;
            r_data_s <= '0;
        end else begin
            r_clk_s  <= {r_clk_s[1:0], io_kbd.ps2_clk};
            r_data_s <= {r_data_s[0], io_kbd.ps2_data};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_frame      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_fall) begin
                r_frame  <= {r_data_s[1], r_frame[10:1]};
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt    <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == c_TO_W'(PS2_TIMEOUT - 1)) begin
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Frame is shifted in LSB first: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    assign w_byte     = r_frame[8:1];
    assign w_frame_ok = ~r_frame[0] & r_frame[10] & (^r_frame[9:1]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_break <= 1'b0;
            r_held  <= 1'b0;
            r_cur   <= '0;
            r_press <= '0;
        end else if (r_frame_done && w_frame_ok) begin
            if (w_byte == 8'hF0) begin
                r_break <= 1'b1;
            end else if (w_byte != 8'hE0) begin
                if (r_break) begin
                    r_break <= 1'b0;
                    r_held  <= 1'b0;
                end else begin
                    r_held <= 1'b1;
                    r_cur  <= w_byte;
                    if (!r_held || (w_byte != r_cur))
                        r_press <= r_press + 8'd1;
                end
            end
        end
    end

    assign w_ascii = f_ascii(r_cur);

    always_comb begin
        w_seg0 = 8'hFF;
        w_seg1 = 8'hFF;
        w_seg2 = 8'hFF;
        w_seg3 = 8'hFF;
        w_seg4 = f_hex(r_press[3:0]);
        w_seg5 = f_hex(r_press[7:4]);
        if (r_held) begin
            w_seg0 = f_hex(r_cur[3:0]);
            w_seg1 = f_hex(r_cur[7:4]);
            if (w_ascii != 8'h00) begin
                w_seg2 = f_hex(w_ascii[3:0]);
                w_seg3 = f_hex(w_ascii[7:4]);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_seg0 <= 8'hFF;
            r_seg1 <= 8'hFF;
            r_seg2 <= 8'hFF;
            r_seg3 <= 8'hFF;
            r_seg4 <= 8'hC0;
            r_seg5 <= 8'hC0;
        end else begin
            r_seg0 <= w_seg0;
            r_seg1 <= w_seg1;
            r_seg2 <= w_seg2;
            r_seg3 <= w_seg3;
            r_seg4 <= w_seg4;
            r_seg5 <= w_seg5;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div <= '0;
            r_led <= 3'b001;
        end else if (r_div == c_DIV_W'(LED_DIV - 1)) begin
            r_div <= '0;
            r_led <= {r_led[1:0], r_led[2]};
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign io_kbd.ledr = {r_led, io_kbd.btn, io_kbd.sw};
    assign io_kbd.seg0 = r_seg0;
    assign io_kbd.seg1 = r_seg1;
    assign io_kbd.seg2 = r_seg2;
    assign io_kbd.seg3 = r_seg3;
    assign io_kbd.seg4 = r_seg4;
    assign io_kbd.seg5 = r_seg5;
    assign io_kbd.seg6 = 8'hFF;
    assign io_kbd.seg7 = 8'hFF;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_display.sv
// ============================================================================
// Module   : tb_ps2_kbd_display
// Brief    : Scoreboard bench for ps2_kbd_display: PS/2 frames in, segs/LEDs out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_kbd_display;

    localparam int c_HALF    = 5;
    localparam int c_TIMEOUT = 100;

    typedef struct packed {
        logic        is_led;
        logic [47:0] segs;   // {seg5,seg4,seg3,seg2,seg1,seg0}
        logic [15:0] led;
    } exp_t;

    logic clk;
    logic resetn;
    ps2_kbd_display_if kbd_if ();

    ps2_kbd_display #(.LED_DIV(4), .PS2_TIMEOUT(c_TIMEOUT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .io_kbd (kbd_if)
    );

    exp_t q_exp[$];
    event ev_sample;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: drains every queued expectation whenever a sample point is signalled.
    initial begin
        exp_t e;
        forever begin
            @(ev_sample);
            if (q_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL queue_empty: got 0 entries expected >0 at %0t", $time);
            end
            while (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                if (e.is_led) begin
                    check("ledr", kbd_if.ledr, e.led);
                end else begin
                    check("seg0", {8'h00, kbd_if.seg0}, {8'h00, e.segs[7:0]});
                    check("seg1", {8'h00, kbd_if.seg1}, {8'h00, e.segs[15:8]});
                    check("seg2", {8'h00, kbd_if.seg2}, {8'h00, e.segs[23:16]});
                    check("seg3", {8'h00, kbd_if.seg3}, {8'h00, e.segs[31:24]});
                    check("seg4", {8'h00, kbd_if.seg4}, {8'h00, e.segs[39:32]});
                    check("seg5", {8'h00, kbd_if.seg5}, {8'h00, e.segs[47:40]});
                    check("seg6", {8'h00, kbd_if.seg6}, 16'h00FF);
                    check("seg7", {8'h00, kbd_if.seg7}, 16'h00FF);
                    check("ledr_lo", {3'b000, kbd_if.ledr[12:0]}, 16'h1FA5);
                end
            end
        end
    end

    task automatic push_seg(input logic [7:0] s0, s1, s2, s3, s4, s5);
        exp_t e;
        e.is_led = 1'b0;
        e.segs   = {s5, s4, s3, s2, s1, s0};
        e.led    = '0;
        q_exp.push_back(e);
    endtask

    task automatic push_led(input logic [2:0] run);
        exp_t e;
        e.is_led = 1'b1;
        e.segs   = '0;
        e.led    = {run, 13'h1FA5};
        q_exp.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample();
        wait_cyc(8);
        -> ev_sample;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kbd_if.ps2_data = f[i];
            wait_cyc(c_HALF);
            kbd_if.ps2_clk = 1'b0;
            wait_cyc(c_HALF);
            kbd_if.ps2_clk = 1'b1;
        end
        kbd_if.ps2_data = 1'b1;
        wait_cyc(4);
    endtask

    task automatic led_run();
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            push_led(3'b001 << ((k / 4) % 3));
            -> ev_sample;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn          = 1'b0;
        kbd_if.ps2_clk  = 1'b1;
        kbd_if.ps2_data = 1'b1;
        kbd_if.sw       = 8'hA5;
        kbd_if.btn      = 5'h1F;

        #25;
        push_seg(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hC0);
        push_led(3'b001);
        -> ev_sample;
        @(negedge clk);
        resetn = 1'b1;
        led_run();

        // Press 'A' (0x1C)
        send_frame(8'h1C, 1'b0, 11);
        push_seg(8'hC6, 8'hF9, 8'hF9, 8'h99, 8'hF9, 8'hC0); sample();

        // Release then press again
        send_frame(8'hF0, 1'b0, 11);
        push_seg(8'hC6, 8'hF9, 8'hF9, 8'h99, 8'hF9, 8'hC0); sample();
        send_frame(8'h1C, 1'b0, 11);
        push_seg(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0); sample();
        send_frame(8'h1C, 1'b0, 11);
        push_seg(8'hC6, 8'hF9, 8'hF9, 8'h99, 8'hA4, 8'hC0); sample();

        // Release, then three repeats count once
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        push_seg(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA4, 8'hC0); sample();
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h1C, 1'b0, 11);
            push_seg(8'hC6, 8'hF9, 8'hF9, 8'h99, 8'hB0, 8'hC0); sample();
        end

        // Bad parity discarded, next valid frame decodes
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        send_frame(8'h1C, 1'b1, 11);
        push_seg(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB0, 8'hC0); sample();
        send_frame(8'h16, 1'b0, 11);
        push_seg(8'h82, 8'hF9, 8'hF9, 8'hB0, 8'h99, 8'hC0); sample();

        // Partial frame aborted by timeout
        send_frame(8'h45, 1'b0, 5);
        wait_cyc(c_TIMEOUT + 10);
        push_seg(8'h82, 8'hF9, 8'hF9, 8'hB0, 8'h99, 8'hC0); sample();
        send_frame(8'h45, 1'b0, 11);
        push_seg(8'h92, 8'h99, 8'hC0, 8'hB0, 8'h92, 8'hC0); sample();

        // E0 prefix ignored; unmapped code blanks ASCII
        send_frame(8'hE0, 1'b0, 11);
        push_seg(8'h92, 8'h99, 8'hC0, 8'hB0, 8'h92, 8'hC0); sample();
        send_frame(8'h05, 1'b0, 11);
        push_seg(8'h92, 8'hC0, 8'hFF, 8'hFF, 8'h82, 8'hC0); sample();

        // Alternate codes to wrap press count 0x06 -> 0xFF -> 0x00
        for (int i = 0; i < 250; i++) begin
            send_frame((i % 2 == 0) ? 8'h32 : 8'h1C, 1'b0, 11);
            if (i == 248) begin
                push_seg(8'hA4, 8'hB0, 8'hA4, 8'h99, 8'h8E, 8'h8E); sample();
            end
        end
        push_seg(8'hC6, 8'hF9, 8'hF9, 8'h99, 8'hC0, 8'hC0); sample();

        // Asynchronous reset mid-run
        #2;
        resetn = 1'b0;
        #1;
        push_seg(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hC0);
        push_led(3'b001);
        -> ev_sample;
        wait_cyc(3);
        @(negedge clk);
        resetn = 1'b1;
        led_run();

        wait_cyc(2);
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: got %0d entries expected 0", q_exp.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_kbd_display.md
PS2_KBD_DISPLAY -- requirements
Module: ps2_kbd_display

Interface
REQ-001 SHALL have parameter LED_DIV, default 5000000, giving the running-light step period in clk cycles.
REQ-002 SHALL have parameter PS2_TIMEOUT, default 50000, giving the number of clk cycles without a ps2_clk falling edge that aborts a partial frame.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btn, input, 5 bits: push buttons.
REQ-006 SHALL have port sw, input, 8 bits: slide switches.
REQ-007 SHALL have port ps2_clk, input, 1 bit: PS/2 clock, asynchronous to clk.
REQ-008 SHALL have port ps2_data, input, 1 bit: PS/2 data, asynchronous to clk.
REQ-009 SHALL have port ledr, output, 16 bits: LED drive, 1 = lit.
REQ-010 SHALL have ports seg0..seg7, output, 8 bits each: seven-segment digits, active-low; bit0..6 = a..g, bit7 = dp.

Function
REQ-011 ps2_clk SHALL be synchronised through a 3-flop chain; a falling edge is stage2=0 while stage3=1; ps2_data SHALL be sampled on that edge.
REQ-012 Frame format SHALL be 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1.
REQ-013 A frame SHALL be accepted only if start=0, stop=1, and the XOR of the 8 data bits and the parity bit is 1; otherwise it is discarded silently.
REQ-014 Frame acceptance SHALL occur the cycle after the 11th falling edge.
REQ-015 PS2_TIMEOUT cycles without a falling edge mid-frame SHALL reset the bit counter to 0.
REQ-016 Accepted byte 0xF0 SHALL set a break flag and change no display.
REQ-017 An accepted byte other than 0xF0 while the break flag is set SHALL clear the break flag and the held state, and blank seg0..seg3.
REQ-018 An accepted byte other than 0xF0 while the break flag is clear SHALL set held=1 and cur_code=byte.
REQ-019 The press counter SHALL increment in the case of REQ-018 only when held was 0 or the byte differs from cur_code, so typematic repeats do not count.
REQ-020 The press counter SHALL be 8 bits and wrap from 0xFF to 0x00.
REQ-021 0xE0 prefix bytes SHALL be ignored (treated as no-ops).
REQ-022 ASCII map SHALL cover set-2 scan codes for A-Z as 0x41-0x5A (e.g. 1C->41, 32->42, 21->43) and 0-9 as 0x30-0x39 (45->30, 16->31, 1E->32, 26->33, 25->34, 2E->35, 36->36, 3D->37, 3E->38, 46->39).
REQ-023 Unmapped codes SHALL give ASCII 0x00.
REQ-024 While held: seg1:seg0 SHALL show cur_code in hex (seg0 = low nibble) and seg3:seg2 SHALL show ASCII in hex; seg3:seg2 SHALL be blank if ASCII = 0x00.
REQ-025 seg5:seg4 SHALL always show the press count in hex.
REQ-026 seg6 and seg7 SHALL always be blank (0xFF).
REQ-027 Hex digit encoding SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E; blank = FF; dp always off.
REQ-028 ledr[7:0] SHALL equal sw combinationally.
REQ-029 ledr[12:8] SHALL equal btn combinationally.
REQ-030 ledr[15:13] SHALL be a one-hot running light that rotates left (13->14->15->13) every LED_DIV cycles.
REQ-031 Seg outputs SHALL be registered and update one cycle after the state change.

Reset
REQ-032 resetn=0 SHALL asynchronously clear the synchroniser, bit counter, timeout counter, break flag, held, cur_code and press counter.
REQ-033 During reset the running light SHALL be 3'b001 at ledr[15:13] with its divider at 0.
REQ-034 During reset seg0..seg3, seg6 and seg7 SHALL be FF and seg5:seg4 SHALL show "00" (C0, C0).
REQ-035 Operation SHALL resume on the first clk edge after resetn rises; a frame in progress at reset SHALL be lost.

Verification
REQ-036 Scenario 1: send frame 0x1C (parity 0) -> seg0=C6, seg1=F9, seg2=F9, seg3=99, seg4=F9, seg5=C0.
REQ-037 Scenario 2: send F0 then 1C -> seg0..seg3 = FF; count stays 1; send 1C again -> count 2 (seg4=A4).
REQ-038 Scenario 3: send 1C three times without break -> count increments only once.
REQ-039 Scenario 4: send 0x1C with wrong parity bit 1 -> no display or count change; the next valid frame decodes correctly.
REQ-040 Scenario 5: abort after 5 bits, wait PS2_TIMEOUT+10 cycles, then send 0x45 -> seg0=92, seg1=99, seg2=C0, seg3=B0.
REQ-041 Scenario 6: sw=0xA5, btn=5'h1F, LED_DIV=4 -> ledr[12:0]=0x1FA5; ledr[15:13] takes 001, 010, 100, 001 at 4-cycle steps; resetn low mid-run restores 001 immediately.
